// File: rtl/float2int_unit.sv
// float2int_unit: converts IEEE-754 single-precision floats to signed 32-bit
// integers through a four-stage pipeline (classify, align, round/saturate,
// sign apply). Out-of-range values and infinities saturate, and NaN gives
// 32'h8000_0000. Both set the sticky ovf flag when they reach the output.
// Default rounding truncates toward zero. Define FLOAT2INT_ROUND_NEAREST_EN
// to round to nearest, ties to even, using the guard and sticky bits.
module float2int_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic              ovf
);

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_NAN    = 2'd2,
    CLS_OVF    = 2'd3
  } cls_e;

  if (DATA_W != 32) begin : g_width_check
    $error("float2int_unit supports only DATA_W = 32");
  end

`ifdef FLOAT2INT_ROUND_NEAREST_EN
  // With rounding, [0.5, 1) still has to reach the rounder.
  localparam logic [7:0] ZERO_EXP_LIMIT = 8'd126;
`else
  localparam logic [7:0] ZERO_EXP_LIMIT = 8'd127;
`endif

  // Stage 1 registers: unpacked operand and its class
  logic        s1_sign_d, s1_sign_q;
  logic [7:0]  s1_exp_d, s1_exp_q;
  logic [22:0] s1_man_d, s1_man_q;
  cls_e        s1_cls_d, s1_cls_q;

  // Stage 2 registers: aligned magnitude
  logic        s2_sign_d, s2_sign_q;
  cls_e        s2_cls_d, s2_cls_q;
  logic [31:0] s2_mag_d, s2_mag_q;
`ifdef FLOAT2INT_ROUND_NEAREST_EN
  logic        s2_guard_d, s2_guard_q;
  logic        s2_sticky_d, s2_sticky_q;
`endif

  // Stage 3 registers: final magnitude plus negate request and error flag
  logic [31:0] s3_mag_d, s3_mag_q;
  logic        s3_neg_d, s3_neg_q;
  logic        s3_flag_d, s3_flag_q;

  // Stage 4 registers: result and sticky overflow
  logic [31:0] out0_d, out0_q;
  logic        ovf_d, ovf_q;

  logic [7:0]  in_exp;
  logic [22:0] in_man;
  cls_e        in_cls;

  logic [23:0] s1_sig;
  logic [31:0] align_mag;
`ifdef FLOAT2INT_ROUND_NEAREST_EN
  logic [47:0] align_wide;
  logic        align_guard;
  logic        align_sticky;
  logic        rnd_inc;
  logic [32:0] rnd_sum;
`endif

  logic [31:0] sat_mag;
  logic        sat_neg;
  logic        sat_flag;

  // Classify the incoming float. NaN is tested first because it shares e = 255 with infinity.
  always_comb begin
    in_exp = in0[30:23];
    in_man = in0[22:0];
    if (in_exp == 8'hFF && in_man != 23'd0) begin
      in_cls = CLS_NAN;
    end else if (in_exp >= 8'd158 && !(in0[31] && in_exp == 8'd158 && in_man == 23'd0)) begin
      in_cls = CLS_OVF;
    end else if (in_exp < ZERO_EXP_LIMIT) begin
      in_cls = CLS_ZERO;
    end else begin
      in_cls = CLS_NORMAL;
    end
  end

  // Stage 1 next state: flush on run, otherwise load while running
  always_comb begin
    s1_sign_d = s1_sign_q;
    s1_exp_d  = s1_exp_q;
    s1_man_d  = s1_man_q;
    s1_cls_d  = s1_cls_q;
    if (run) begin
      s1_sign_d = 1'b0;
      s1_exp_d  = 8'd0;
      s1_man_d  = 23'd0;
      s1_cls_d  = CLS_NORMAL;
    end else if (running) begin
      s1_sign_d = in0[31];
      s1_exp_d  = in_exp;
      s1_man_d  = in_man;
      s1_cls_d  = in_cls;
    end
  end

  // Align the significand so the binary point sits below bit 0 of the magnitude
  always_comb begin
    s1_sig    = {1'b1, s1_man_q};
    align_mag = 32'd0;
`ifdef FLOAT2INT_ROUND_NEAREST_EN
    align_wide   = 48'd0;
    align_guard  = 1'b0;
    align_sticky = 1'b0;
`endif
    if (s1_cls_q == CLS_NORMAL) begin
      if (s1_exp_q >= 8'd150) begin
        align_mag = {8'd0, s1_sig} << (s1_exp_q - 8'd150);
      end else begin
`ifdef FLOAT2INT_ROUND_NEAREST_EN
        align_wide   = {s1_sig, 24'd0} >> (8'd150 - s1_exp_q);
        align_mag    = {8'd0, align_wide[47:24]};
        align_guard  = align_wide[23];
        align_sticky = |align_wide[22:0];
`else
        align_mag = {8'd0, s1_sig >> (8'd150 - s1_exp_q)};
`endif
      end
    end
  end

  // Stage 2 next state
  always_comb begin
    s2_sign_d = s2_sign_q;
    s2_cls_d  = s2_cls_q;
    s2_mag_d  = s2_mag_q;
`ifdef FLOAT2INT_ROUND_NEAREST_EN
    s2_guard_d  = s2_guard_q;
    s2_sticky_d = s2_sticky_q;
`endif
    if (run) begin
      s2_sign_d = 1'b0;
      s2_cls_d  = CLS_NORMAL;
      s2_mag_d  = 32'd0;
`ifdef FLOAT2INT_ROUND_NEAREST_EN
      s2_guard_d  = 1'b0;
      s2_sticky_d = 1'b0;
`endif
    end else if (running) begin
      s2_sign_d = s1_sign_q;
      s2_cls_d  = s1_cls_q;
      s2_mag_d  = align_mag;
`ifdef FLOAT2INT_ROUND_NEAREST_EN
      s2_guard_d  = align_guard;
      s2_sticky_d = align_sticky;
`endif
    end
  end

  // Round (optionally) and substitute saturation values for NaN and overflow classes
  always_comb begin
    sat_mag  = 32'd0;
    sat_neg  = 1'b0;
    sat_flag = 1'b0;
`ifdef FLOAT2INT_ROUND_NEAREST_EN
    rnd_inc = s2_guard_q & (s2_sticky_q | s2_mag_q[0]);
    rnd_sum = {1'b0, s2_mag_q} + {32'd0, rnd_inc};
`endif
    case (s2_cls_q)
      CLS_NAN: begin
        sat_mag  = 32'h8000_0000;
        sat_flag = 1'b1;
      end
      CLS_OVF: begin
        sat_mag  = s2_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        sat_flag = 1'b1;
      end
      CLS_ZERO: begin
        sat_mag = 32'd0;
      end
      default: begin
`ifdef FLOAT2INT_ROUND_NEAREST_EN
        if (!s2_sign_q && rnd_sum[32:31] != 2'b00) begin
          sat_mag  = 32'h7FFF_FFFF;
          sat_flag = 1'b1;
        end else begin
          sat_mag = rnd_sum[31:0];
          sat_neg = s2_sign_q;
        end
`else
        sat_mag = s2_mag_q;
        sat_neg = s2_sign_q;
`endif
      end
    endcase
  end

  // Stage 3 next state
  always_comb begin
    s3_mag_d  = s3_mag_q;
    s3_neg_d  = s3_neg_q;
    s3_flag_d = s3_flag_q;
    if (run) begin
      s3_mag_d  = 32'd0;
      s3_neg_d  = 1'b0;
      s3_flag_d = 1'b0;
    end else if (running) begin
      s3_mag_d  = sat_mag;
      s3_neg_d  = sat_neg;
      s3_flag_d = sat_flag;
    end
  end

  // Stage 4: apply sign and accumulate the sticky flag. Negating 2^31 naturally yields -2^31.
  always_comb begin
    out0_d = out0_q;
    ovf_d  = ovf_q;
    if (run) begin
      out0_d = 32'd0;
      ovf_d  = 1'b0;
    end else if (running) begin
      out0_d = s3_neg_q ? (~s3_mag_q + 32'd1) : s3_mag_q;
      ovf_d  = ovf_q | s3_flag_q;
    end
  end

  // All pipeline state, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_sign_q <= 1'b0;
      s1_exp_q  <= 8'd0;
      s1_man_q  <= 23'd0;
      s1_cls_q  <= CLS_NORMAL;
      s2_sign_q <= 1'b0;
      s2_cls_q  <= CLS_NORMAL;
      s2_mag_q  <= 32'd0;
`ifdef FLOAT2INT_ROUND_NEAREST_EN
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
`endif
      s3_mag_q  <= 32'd0;
      s3_neg_q  <= 1'b0;
      s3_flag_q <= 1'b0;
      out0_q    <= 32'd0;
      ovf_q     <= 1'b0;
    end else begin
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_man_q  <= s1_man_d;
      s1_cls_q  <= s1_cls_d;
      s2_sign_q <= s2_sign_d;
      s2_cls_q  <= s2_cls_d;
      s2_mag_q  <= s2_mag_d;
`ifdef FLOAT2INT_ROUND_NEAREST_EN
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
`endif
      s3_mag_q  <= s3_mag_d;
      s3_neg_q  <= s3_neg_d;
      s3_flag_q <= s3_flag_d;
      out0_q    <= out0_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out0 = out0_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_float2int_unit.sv
// tb_float2int_unit: directed vectors for float2int_unit. The driver pushes the
// hand-computed result of every tracked input into a queue. The monitor follows
// pipeline occupancy and pops and compares each result as it leaves stage 4.
module tb_float2int_unit;

`ifdef FLOAT2INT_ROUND_NEAREST_EN
  localparam bit RN = 1'b1;
`else
  localparam bit RN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] stim;
    logic [31:0] out;
    logic        ovf;
  } sb_entry_t;

  logic        clk;
  logic        rst;
  logic        running;
  logic        run;
  logic [31:0] in0;
  logic [31:0] out0;
  logic        ovf;
  logic        in_valid;

  sb_entry_t sb_q[$];
  int tests_run;
  int fail_count;

  float2int_unit #(.DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .running (running),
    .run     (run),
    .in0     (in0),
    .out0    (out0),
    .ovf     (ovf)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached with %0d results pending, expected 0", sb_q.size());
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] stim,
                             input logic [31:0] got_out, input logic got_ovf,
                             input logic [31:0] exp_out, input logic exp_ovf);
    tests_run++;
    if (got_out !== exp_out || got_ovf !== exp_ovf) begin
      fail_count++;
      $display("[TB] FAIL %s in0=%h: out0 got %h want %h, ovf got %b want %b",
               name, stim, got_out, exp_out, got_ovf, exp_ovf);
    end
  endtask

  // Drive one tracked input for the next edge and record its expected result
  task automatic applyStimulus(input logic [31:0] val, input logic [31:0] exp_out,
                               input logic exp_ovf);
    sb_entry_t e;
    e.stim = val;
    e.out  = exp_out;
    e.ovf  = exp_ovf;
    sb_q.push_back(e);
    in0      = val;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in0      = 32'd0;
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    in0      = 32'd0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drainPipe();
    int budget;
    budget   = 20;
    in_valid = 1'b0;
    in0      = 32'd0;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb_q.size() != 0) begin
      tests_run++;
      fail_count++;
      $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // One-cycle run pulse; in-flight results are discarded by the DUT, so drop their expectations
  task automatic pulseRun();
    run      = 1'b1;
    in_valid = 1'b0;
    in0      = 32'd0;
    sb_q.delete();
    @(negedge clk);
    run = 1'b0;
    checkOutput("run_clear", 32'd0, out0, ovf, 32'd0, 1'b0);
  endtask

  // Monitor: mirrors pipeline occupancy and checks each tracked result as it reaches out0
  initial begin : monitor
    logic [3:0] vpipe;
    logic       adv;
    sb_entry_t  e;
    vpipe = 4'd0;
    forever begin
      @(posedge clk);
      adv = 1'b0;
      if (!rst || run) begin
        vpipe = 4'd0;
      end else if (running) begin
        vpipe = {vpipe[2:0], in_valid};
        adv   = 1'b1;
      end
      #1;
      if (adv && vpipe[3]) begin
        if (sb_q.size() == 0) begin
          tests_run++;
          fail_count++;
          $display("[TB] FAIL sb_underflow: out0 got %h with no expected result queued", out0);
        end else begin
          e = sb_q.pop_front();
          checkOutput("result", e.stim, out0, ovf, e.out, e.ovf);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    tests_run  = 0;
    fail_count = 0;
    rst      = 1'b0;
    running  = 1'b0;
    run      = 1'b0;
    in0      = 32'd0;
    in_valid = 1'b0;

    @(negedge clk);
    checkOutput("reset_state", 32'd0, out0, ovf, 32'd0, 1'b0);
    rst     = 1'b1;
    running = 1'b1;

    // Basic conversions
    applyStimulus(32'h3F80_0000, 32'h0000_0001, 1'b0);
    applyStimulus(32'hC020_0000, 32'hFFFF_FFFE, 1'b0);
    applyStimulus(32'h4060_0000, RN ? 32'h0000_0004 : 32'h0000_0003, 1'b0);
    applyStimulus(32'h3F40_0000, RN ? 32'h0000_0001 : 32'h0000_0000, 1'b0);
    applyStimulus(32'h42F6_E979, 32'h0000_007B, 1'b0);
    applyStimulus(32'hC6FF_FE00, 32'hFFFF_8001, 1'b0);
    applyStimulus(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0);
    applyStimulus(32'h4B00_0000, 32'h0080_0000, 1'b0);
    drainPipe();

    // Range edges
    applyStimulus(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1);
    drainPipe();
    pulseRun();
    applyStimulus(32'hCF00_0000, 32'h8000_0000, 1'b0);
    applyStimulus(32'h7FC0_0000, 32'h8000_0000, 1'b1);
    drainPipe();
    pulseRun();

    // Small values, signed zero, rounding boundaries, infinities
    applyStimulus(32'h0000_0001, 32'h0000_0000, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0000_0000, 1'b0);
    applyStimulus(32'h3F00_0000, 32'h0000_0000, 1'b0);
    applyStimulus(32'h3F00_0001, RN ? 32'h0000_0001 : 32'h0000_0000, 1'b0);
    applyStimulus(32'h3FC0_0000, RN ? 32'h0000_0002 : 32'h0000_0001, 1'b0);
    applyStimulus(32'hBFC0_0000, RN ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 1'b0);
    applyStimulus(32'h3EFF_FFFF, 32'h0000_0000, 1'b0);
    applyStimulus(32'hFF80_0000, 32'h8000_0000, 1'b1);
    applyStimulus(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1);
    drainPipe();
    pulseRun();

    // Stall after the first result has appeared
    applyStimulus(32'h40A0_0000, 32'd5, 1'b0);
    applyStimulus(32'h4120_0000, 32'd10, 1'b0);
    applyStimulus(32'h41A0_0000, 32'd20, 1'b0);
    applyStimulus(32'h4220_0000, 32'd40, 1'b0);
    running = 1'b0;
    in0     = 32'h7FC0_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_hold", 32'd0, out0, ovf, 32'd5, 1'b0);
    end
    running = 1'b1;
    drainPipe();

    // Flush with a NaN sitting in stage 2
    applyStimulus(32'h4120_0000, 32'd10, 1'b0);
    idleCycles(1);
    in0 = 32'h7FC0_0000;
    @(negedge clk);
    idleCycles(1);
    pulseRun();
    idleCycles(5);
    checkOutput("flush_no_ovf", 32'h7FC0_0000, out0, ovf, 32'd0, 1'b0);

    // Asynchronous reset in the middle of a stream
    applyStimulus(32'h7FC0_0000, 32'h8000_0000, 1'b1);
    drainPipe();
    applyStimulus(32'h4120_0000, 32'd10, 1'b1);
    applyStimulus(32'h4228_0000, 32'd42, 1'b1);
    applyStimulus(32'h40A0_0000, 32'd5, 1'b1);
    applyStimulus(32'h41A0_0000, 32'd20, 1'b1);
    #2;
    rst = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("async_reset", 32'd0, out0, ovf, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'h42C8_0000, 32'd100, 1'b0);
    checkOutput("post_reset_empty", 32'd0, out0, ovf, 32'd0, 1'b0);
    idleCycles(1);
    checkOutput("post_reset_empty", 32'd0, out0, ovf, 32'd0, 1'b0);
    idleCycles(1);
    checkOutput("post_reset_empty", 32'd0, out0, ovf, 32'd0, 1'b0);
    drainPipe();
    idleCycles(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/float2int_unit.md
Name: float2int_unit

Overview:
- Versat functional unit that converts IEEE-754 single-precision floats to signed 32-bit integers.
- Sits directly downstream of the unit that converts integers to floats. Its input is fed by float datapaths, and its output returns integers to the integer datapath.
- Four-stage pipeline, one result per cycle. Default rounding is truncation toward zero (C cast semantics), with saturation on out-of-range inputs.

Parameters:
- DATA_W, 32, data width; only 32 is supported, and elaboration fails on any other value.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; clears all pipeline registers and flags
- running  in  1  accelerator active; pipeline advances only while high
- run  in  1  one-cycle start pulse for a new accelerator run
- in0  in  DATA_W  float operand (sign[31], exp[30:23], mant[22:0])
- out0  out  DATA_W  signed integer result; versat_latency = 4
- ovf  out  1  sticky flag: overflow or NaN seen since the last run pulse

Behaviour:
- Reset (rst low, asynchronous): all stage registers = 0, out0 = 0, ovf = 0. Release is synchronous to clk.
- Pipeline advance: all stages load when running = 1. When running = 0, all stages hold their value and out0 is stable.
- run pulse: clears ovf and flushes stages 1-3 to zero in the same cycle. The stage-4 register also loads 0, so out0 = 0 in the cycle after run.
- Latency: in0 sampled at edge N appears on out0 after edge N+3, counting only advancing edges. Throughput is 1 result per advancing cycle.
- Stage 1 (unpack/classify):
  - e = exp, m = {1, mant}.
  - Class ZERO if e < 127: covers zero, denormals and |x| < 1.
  - Class NAN if e = 255 and mant != 0.
  - Class OVF if e >= 158, except the exact -2^31 case (sign = 1, e = 158, mant = 0), which is class NORMAL.
  - Otherwise class NORMAL.
  - Infinity has e = 255 and mant = 0, so it falls into class OVF.
- Stage 2 (align):
  - Magnitude mag[31:0] = m << (e - 150) if e >= 150, else m >> (150 - e).
  - The bits shifted out are retained as guard and sticky for the optional rounding feature.
- Stage 3 (round/saturate):
  - Truncation drops the shifted-out bits.
  - NAN -> 32'h8000_0000. OVF with sign 0 -> 32'h7FFF_FFFF. OVF with sign 1 -> 32'h8000_0000.
  - ZERO -> 0; -0.0 also gives 0.
  - Any NAN or OVF result raises a per-stage flag bit.
- Stage 4 (sign apply/output):
  - out0 = sign ? -mag : mag for NORMAL; the saturated value otherwise.
  - -2^31 yields 32'h8000_0000 from the two's-complement negate of 32'h8000_0000, with no flag raised.
  - ovf |= stage flag when advancing.
- Simultaneous run and running: the flush/clear takes priority over load.
- ovf is set only by results reaching stage 4. Flagged values flushed by run never set ovf.

Optional Feature:
- Macro: FLOAT2INT_ROUND_NEAREST_EN.
- When defined, stage 3 rounds to nearest, ties to even, using guard and sticky:
  - The magnitude increments when guard = 1 and (sticky = 1 or lsb = 1).
  - For e = 126 (0.5 <= |x| < 1), the result is 0 at exactly 0.5 and 1 otherwise. Values with e < 126 give 0.
  - A positive magnitude that rounds to 2^31 saturates to 32'h7FFF_FFFF and raises the flag. This is unreachable for single precision but the check is still present.
- When not defined: truncation only, guard/sticky logic is not synthesized, and the e = 126 case is class ZERO.

Test Plan:
- Reset then stream 3F80_0000, C020_0000, 4060_0000, 3F40_0000 with running = 1:
  - Outputs after 4 cycles: 1, FFFF_FFFE, 3, 0.
  - With FLOAT2INT_ROUND_NEAREST_EN: 1, FFFF_FFFE, 4, 1.
- Range edges: 4F00_0000 -> 7FFF_FFFF with ovf = 1. Pulse run, then CF00_0000 -> 8000_0000 with ovf = 0. Then 7FC0_0000 -> 8000_0000 with ovf = 1.
- Infinity and denormal: FF80_0000 -> 8000_0000 with ovf = 1. 0000_0001 -> 0. 8000_0000 (-0.0) -> 0.
- Stall: stream 4 values, drop running for 3 cycles mid-stream. out0 holds during the stall, and the sequence resumes with no loss or duplication.
- run flush: with a NaN in stage 2, pulse run. out0 goes to 0 the next cycle and ovf stays 0.
- Async reset: assert rst low mid-stream between clock edges. out0 and ovf go to 0 immediately, and the first output after release comes from a fresh input after 4 cycles.
